axis_byte_packer: RTL and testbench

AXIS_BYTE_PACKER -- requirements
Module: axis_byte_packer

---
 rtl/axis_byte_packer.sv | 133 +++++++++++++
 tb/tb_axis_byte_packer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_packer.sv
// AXI-Stream byte packer: compacts partially-kept input beats into full output beats,
// with optional output lane reversal and a sticky flag for non-contiguous tkeep.
module axis_byte_packer #(
    parameter int unsigned DATA_BYTES = 8,
    parameter bit          SWAP_BYTES = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [DATA_BYTES*8-1:0] i_tdata,
    input  logic [DATA_BYTES-1:0]   i_tkeep,
    input  logic                    i_tvalid,
    input  logic                    i_tlast,
    output logic                    o_tready,
    output logic [DATA_BYTES*8-1:0] o_tdata,
    output logic [DATA_BYTES-1:0]   o_tkeep,
    output logic                    o_tvalid,
    output logic                    o_tlast,
    input  logic                    i_tready,
    output logic                    o_err_keep
);

    localparam int unsigned DW = DATA_BYTES * 8;
    localparam int unsigned BB = 2 * DATA_BYTES;
    localparam int unsigned BW = BB * 8;
    localparam int unsigned CW = $clog2(BB + 1);

    if (DATA_BYTES < 2 || (DATA_BYTES & (DATA_BYTES - 1)) != 0) begin : g_param_check
        $error("axis_byte_packer: DATA_BYTES must be a power of 2 and at least 2");
    end

    logic [BW-1:0] sbuf_q, sbuf_n;
    logic [CW-1:0] cnt_q, cnt_n, cnt_s, popped, nb;
    logic          fl_q, fl_n;
    logic          zl_q, zl_n;
    logic          accept, pop, err_hit;
    logic [DW-1:0] data_m;
    logic [BW-1:0] ins;

    logic [DW-1:0]         data_n;
    logic [DATA_BYTES-1:0] keep_n;
    logic                  valid_n, last_n, ready_n, err_n;

    assign accept = i_tvalid && o_tready;
    assign pop    = o_tvalid && i_tready;

    // Accepted byte count: index of the lowest cleared keep bit.
    always_comb begin
        nb = CW'(DATA_BYTES);
        for (int k = int'(DATA_BYTES) - 1; k >= 0; k--) begin
            if (!i_tkeep[k]) nb = CW'(k);
        end
    end

    assign err_hit = (i_tkeep >> nb) != '0;
    assign popped  = (cnt_q >= CW'(DATA_BYTES)) ? CW'(DATA_BYTES) : cnt_q;

    always_comb begin
        data_m = '0;
        for (int k = 0; k < int'(DATA_BYTES); k++) begin
            if (CW'(k) < nb) data_m[8*k +: 8] = i_tdata[8*k +: 8];
        end
    end

    // Buffer bytes at and above cnt are always zero, so appending is a shifted OR.
    always_comb begin
        sbuf_n = sbuf_q;
        cnt_s  = cnt_q;
        fl_n   = fl_q;
        zl_n   = zl_q;
        ins    = '0;
        if (pop) begin
            sbuf_n = sbuf_q >> DW;
            cnt_s  = cnt_q - popped;
            zl_n   = 1'b0;
            if (o_tlast) fl_n = 1'b0;
        end
        cnt_n = cnt_s;
        if (accept) begin
            ins    = BW'(data_m) << {cnt_s, 3'b000};
            sbuf_n = sbuf_n | ins;
            cnt_n  = cnt_s + nb;
            if (i_tlast) begin
                fl_n = 1'b1;
                if (nb == '0 && cnt_s == '0) zl_n = 1'b1;
            end
        end
    end

    always_comb begin
        valid_n = (cnt_n >= CW'(DATA_BYTES)) || (fl_n && cnt_n != '0) || zl_n;
        last_n  = valid_n && fl_n && (cnt_n <= CW'(DATA_BYTES));
        ready_n = !fl_n && (cnt_n <= CW'(DATA_BYTES));
        err_n   = o_err_keep || (accept && err_hit);
        data_n  = '0;
        keep_n  = '0;
        for (int i = 0; i < int'(DATA_BYTES); i++) begin
            if (SWAP_BYTES) begin
                data_n[8*i +: 8] = sbuf_n[8*(int'(DATA_BYTES)-1-i) +: 8];
                keep_n[i]        = CW'(int'(DATA_BYTES) - 1 - i) < cnt_n;
            end else begin
                data_n[8*i +: 8] = sbuf_n[8*i +: 8];
                keep_n[i]        = CW'(i) < cnt_n;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sbuf_q     <= '0;
            cnt_q      <= '0;
            fl_q       <= 1'b0;
            zl_q       <= 1'b0;
            o_tready   <= 1'b0;
            o_tdata    <= '0;
            o_tkeep    <= '0;
            o_tvalid   <= 1'b0;
            o_tlast    <= 1'b0;
            o_err_keep <= 1'b0;
        end else begin
            sbuf_q     <= sbuf_n;
            cnt_q      <= cnt_n;
            fl_q       <= fl_n;
            zl_q       <= zl_n;
            o_tready   <= ready_n;
            o_tdata    <= data_n;
            o_tkeep    <= keep_n;
            o_tvalid   <= valid_n;
            o_tlast    <= last_n;
            o_err_keep <= err_n;
        end
    end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Scoreboard bench for axis_byte_packer (DATA_BYTES=4): a byte-stream packet model
// predicts output beats; a normal and a lane-swapped instance share all inputs.
`timescale 1ns/1ps
module tb_axis_byte_packer;

    localparam int unsigned DB = 4;
    localparam int unsigned DW = DB * 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [DB-1:0] keep;
        logic          last;
        int            cyc;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [DW-1:0] i_tdata = '0;
    logic [DB-1:0] i_tkeep = '0;
    logic          i_tvalid = 1'b0;
    logic          i_tlast = 1'b0;
    logic          i_tready;
    logic          rdy_fix = 1'b1;
    logic          rdy_rand = 1'b0;
    logic          rdy_r = 1'b1;

    logic          o_tready, o_tvalid, o_tlast, o_err_keep;
    logic [DW-1:0] o_tdata;
    logic [DB-1:0] o_tkeep;
    logic          s_tready, s_tvalid, s_tlast, s_err;
    logic [DW-1:0] s_tdata;
    logic [DB-1:0] s_tkeep;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   total = 0;
    logic err_exp = 1'b0;
    logic err_ref = 1'b0;
    logic chk_on = 1'b0;
    logic chk_lat = 1'b0;
    logic [7:0] pend[$];
    exp_t exp_q[$];

    assign i_tready = rdy_rand ? rdy_r : rdy_fix;

    axis_byte_packer #(.DATA_BYTES(DB), .SWAP_BYTES(1'b0)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_tdata(i_tdata), .i_tkeep(i_tkeep),
        .i_tvalid(i_tvalid), .i_tlast(i_tlast), .o_tready(o_tready),
        .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tvalid(o_tvalid),
        .o_tlast(o_tlast), .i_tready(i_tready), .o_err_keep(o_err_keep)
    );

    axis_byte_packer #(.DATA_BYTES(DB), .SWAP_BYTES(1'b1)) u_swp (
        .i_clk(i_clk), .i_rst(i_rst), .i_tdata(i_tdata), .i_tkeep(i_tkeep),
        .i_tvalid(i_tvalid), .i_tlast(i_tlast), .o_tready(s_tready),
        .o_tdata(s_tdata), .o_tkeep(s_tkeep), .o_tvalid(s_tvalid),
        .o_tlast(s_tlast), .i_tready(i_tready), .o_err_keep(s_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        cyc     <= cyc + 1;
        err_ref <= err_exp;
    end

    always @(posedge i_clk) begin
        #1;
        rdy_r <= ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int nb_of(input logic [DB-1:0] k);
        for (int i = 0; i < int'(DB); i++) if (!k[i]) return i;
        return int'(DB);
    endfunction

    function automatic logic [DW-1:0] rev_data(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DB); i++) r[8*i +: 8] = d[8*(int'(DB)-1-i) +: 8];
        return r;
    endfunction

    function automatic logic [DB-1:0] rev_keep(input logic [DB-1:0] k);
        logic [DB-1:0] r;
        for (int i = 0; i < int'(DB); i++) r[i] = k[int'(DB)-1-i];
        return r;
    endfunction

    task automatic emit(input logic l, input int n);
        exp_t e;
        e.data = '0;
        e.keep = '0;
        for (int i = 0; i < n; i++) begin
            e.data[8*i +: 8] = pend.pop_front();
            e.keep[i] = 1'b1;
        end
        e.last = l;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    // Packet model: bytes form a stream chopped into DB-byte beats; the final one carries tlast.
    task automatic model_accept(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
        int nb;
        nb = nb_of(k);
        if ((k >> nb) != '0) err_exp = 1'b1;
        for (int i = 0; i < nb; i++) pend.push_back(d[8*i +: 8]);
        total += nb;
        if (!l) begin
            while (pend.size() >= int'(DB)) emit(1'b0, int'(DB));
        end else begin
            while (pend.size() > int'(DB)) emit(1'b0, int'(DB));
            emit(1'b1, pend.size());
            total = 0;
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
        int waited;
        waited   = 0;
        i_tdata  = d;
        i_tkeep  = k;
        i_tlast  = l;
        i_tvalid = 1'b1;
        @(negedge i_clk);
        while (!o_tready) begin
            waited++;
            if (waited > 300) begin
                checks++;
                fails++;
                $display("FAIL send_timeout: o_tready stayed 0 for %0d cycles, expected 1", waited);
                i_tvalid = 1'b0;
                tick();
                return;
            end
            @(negedge i_clk);
        end
        chk("swap_tready", 64'(s_tready), 64'd1);
        if (chk_lat) chk("tready_stall", 64'(waited), 64'd0);
        model_accept(d, k, l);
        tick();
        i_tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
        tick();
    endtask

    // Scoreboard monitor: pop and compare on every output handshake.
    always @(negedge i_clk) begin
        exp_t e;
        if (chk_on && !i_rst && o_tvalid && i_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h last %0b, expected none",
                         o_tdata, o_tkeep, o_tlast);
            end else begin
                e = exp_q.pop_front();
                chk("tdata", 64'(o_tdata), 64'(e.data));
                chk("tkeep", 64'(o_tkeep), 64'(e.keep));
                chk("tlast", 64'(o_tlast), 64'(e.last));
                chk("swap_tvalid", 64'(s_tvalid), 64'd1);
                chk("swap_tdata", 64'(s_tdata), 64'(rev_data(e.data)));
                chk("swap_tkeep", 64'(s_tkeep), 64'(rev_keep(e.keep)));
                chk("swap_tlast", 64'(s_tlast), 64'(e.last));
                if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd1);
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_on) begin
            chk("err_keep", 64'(o_err_keep), 64'(err_ref));
            chk("swap_err_keep", 64'(s_err), 64'(err_ref));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] k;
        logic          l;
        int            nb;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_tready", 64'(o_tready), 64'd0);
        chk("rst_tdata", 64'(o_tdata), 64'd0);
        chk("rst_tkeep", 64'(o_tkeep), 64'd0);
        chk("rst_tlast", 64'(o_tlast), 64'd0);
        chk("rst_err", 64'(o_err_keep), 64'd0);
        tick();
        i_rst  = 1'b0;
        chk_on = 1'b1;
        @(negedge i_clk);
        chk("tready_before_edge", 64'(o_tready), 64'd0);
        tick();
        @(negedge i_clk);
        chk("tready_after_reset", 64'(o_tready), 64'd1);
        tick();

        // Packing of two-byte beats
        send_beat(32'h0000BBAA, 4'h3, 1'b0);
        send_beat(32'h0000DDCC, 4'h3, 1'b0);
        send_beat(32'h0000FFEE, 4'h3, 1'b1);
        drain(50);

        // Back-to-back full beats, one output per cycle
        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) send_beat($urandom, 4'hF, 1'(i == 7));
        drain(50);
        chk_lat = 1'b0;

        // Backpressure with six bytes buffered
        rdy_fix = 1'b0;
        send_beat(32'h44332211, 4'hF, 1'b0);
        send_beat(32'h99886655, 4'h3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("bp_tready", 64'(o_tready), 64'd0);
            chk("bp_tvalid", 64'(o_tvalid), 64'd1);
            chk("bp_tdata", 64'(o_tdata), 64'h44332211);
            chk("bp_tkeep", 64'(o_tkeep), 64'hF);
            tick();
        end
        rdy_fix = 1'b1;
        send_beat(32'hAAAAAA77, 4'h1, 1'b1);
        drain(50);

        // Non-contiguous keep: only byte 0 packed, flag sticks
        send_beat(32'h00330011, 4'h5, 1'b0);
        send_beat(32'h12345678, 4'h0, 1'b1);
        drain(50);
        @(negedge i_clk);
        chk("err_set", 64'(o_err_keep), 64'd1);
        tick();

        // Lane swap on a full last beat
        send_beat(32'h11223344, 4'hF, 1'b1);
        drain(50);

        // Zero-byte last at empty buffer
        send_beat(32'hDEADBEEF, 4'h0, 1'b1);
        drain(50);

        // Reset with six bytes buffered
        rdy_fix = 1'b0;
        send_beat(32'hA1A2A3A4, 4'hF, 1'b0);
        send_beat(32'h0000B5B6, 4'h3, 1'b0);
        tick();
        i_rst   = 1'b1;
        err_exp = 1'b0;
        exp_q.delete();
        pend.delete();
        total = 0;
        tick();
        @(negedge i_clk);
        chk("mid_rst_tvalid", 64'(o_tvalid), 64'd0);
        chk("mid_rst_tready", 64'(o_tready), 64'd0);
        chk("mid_rst_tkeep", 64'(o_tkeep), 64'd0);
        chk("mid_rst_tdata", 64'(o_tdata), 64'd0);
        chk("mid_rst_tlast", 64'(o_tlast), 64'd0);
        tick();
        i_rst   = 1'b0;
        rdy_fix = 1'b1;
        @(negedge i_clk);
        chk("no_stale_tvalid", 64'(o_tvalid), 64'd0);
        tick();
        @(negedge i_clk);
        chk("post_rst_tready", 64'(o_tready), 64'd1);
        chk("post_rst_tvalid", 64'(o_tvalid), 64'd0);
        tick();
        send_beat(32'h00C3C4C5, 4'h3, 1'b1);
        drain(50);

        // Randomized traffic with random downstream readiness
        rdy_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            nb = int'($urandom_range(0, DB));
            k  = DB'((1 << nb) - 1);
            if ($urandom_range(0, 9) == 0) k = DB'($urandom);
            l  = ($urandom_range(0, 4) == 0);
            if (l && nb_of(k) == 0 && total > 0 && (total % int'(DB)) == 0) k = DB'(1);
            send_beat($urandom, k, l);
            if ($urandom_range(0, 3) == 0) tick();
        end
        if (total != 0) send_beat($urandom, DB'(1), 1'b1);
        drain(2000);
        rdy_rand = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
